// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port memory slave with valid/ready request and
// response channels, RISC-V load/store size and sign handling, and a fixed
// number of wait states between accept and response.
//
// Optional build macro MISALIGN_TRAP_EN: when defined, misaligned halfword
// and word accesses complete with resp_err instead of being force-aligned.
//
// state  | meaning
// IDLE   | ready for a request, req_ready = 1
// WAIT   | request latched, counting wait states down to zero
// RESP   | response presented, held until resp_ready
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] DATA_BASE   = 32'h0001_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clockMem,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  // Counter runs WAIT_LD..0, giving WAIT_CYCLES cycles in WAIT.
  localparam logic [3:0]  WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic        accept;
  logic        enter_resp;

  // Current transaction view: live request while IDLE (zero-wait path),
  // latched copy afterwards.
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic [31:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              f3_ok;
  logic              misal;
  logic              err_next;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [31:0]       rdata_next;
  logic [3:0]        wr_be;
  logic [31:0]       wr_word;
  logic              mem_we;

  assign accept = req_valid & (state_q == S_IDLE);

  // State register
  always_ff @(posedge clockMem or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, wait counter and the RESP-entry strobe
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end else begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // Select live request or latched transaction
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = req_we;
      cur_f3    = req_funct3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_f3    = f3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  // Address range, funct3 legality, alignment and resulting error
  always_comb begin
    offset   = cur_addr - DATA_BASE;
    in_range = (cur_addr >= DATA_BASE) && ((offset >> (ADDR_W + 2)) == 32'd0);
    idx      = offset[ADDR_W+1:2];
    lane     = cur_addr[1:0];
    if (cur_we) begin
      f3_ok = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010);
    end else begin
      f3_ok = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010) ||
              (cur_f3 == 3'b100) || (cur_f3 == 3'b101);
    end
    misal = 1'b0;
`ifdef MISALIGN_TRAP_EN
    // funct3[1:0] = 01 covers LH/LHU/SH, 10 covers LW/SW
    if (cur_f3[1:0] == 2'b01) begin
      misal = lane[0];
    end else if (cur_f3[1:0] == 2'b10) begin
      misal = (lane != 2'b00);
    end
`endif
    err_next = ~f3_ok | ~in_range | misal;
  end

  // Load extraction and sign/zero extension
  always_comb begin
    rd_word  = mem_q[idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = 32'd0;
    case (cur_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, rd_byte};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
    rdata_next = (err_next | cur_we) ? 32'd0 : load_val;
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    wr_be   = 4'b0000;
    wr_word = cur_wdata;
    case (cur_f3)
      3'b000: begin
        wr_be   = 4'b0001 << lane;
        wr_word = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{cur_wdata[15:0]}};
      end
      3'b010: begin
        wr_be   = 4'b1111;
        wr_word = cur_wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_word = cur_wdata;
      end
    endcase
    // Gated by reset so a zero-wait store cannot slip in while held in reset
    mem_we = enter_resp & cur_we & ~err_next & reset;
  end

  // Next values of the transaction latch and response registers
  always_comb begin
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = req_we;
      f3_d    = req_funct3;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    if (enter_resp) begin
      rdata_d = rdata_next;
      err_d   = err_next;
    end
  end

  // Transaction latch, wait counter and response registers
  always_ff @(posedge clockMem or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Word array with byte-enable writes; contents survive reset
  always_ff @(posedge clockMem) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int unsigned ADDR_W      = 10;
  localparam logic [31:0] BASE        = 32'h0001_0000;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int          DEPTH       = 1 << ADDR_W;

  logic        clockMem;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks;
  int errors;

  logic [31:0] mdl [DEPTH];

  data_mem_responder #(
    .ADDR_W(ADDR_W),
    .DATA_BASE(BASE),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clockMem(clockMem),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  initial clockMem = 1'b0;
  always #5 clockMem = ~clockMem;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] fill_val(input int i);
    return 32'hA5A5_0000 + i * 32'h0003_0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: memory as a plain word array, accesses computed
  // with shifts and masks from the address arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    longint a;
    int     widx;
    int     ln;
    bit     inr;
    bit     f3ok;
    bit     mis;
    logic [31:0] w;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] mask;
    a    = longint'(addr);
    inr  = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
    widx = int'((a - longint'(BASE)) / 4);
    ln   = int'(addr % 4);
    f3ok = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (f3 == 3'd1 || f3 == 3'd5) mis = (ln % 2) != 0;
    if (f3 == 3'd2) mis = ln != 0;
`endif
    err = !f3ok || !inr || mis;
    rd  = 32'd0;
    if (err) return;
    w = mdl[widx];
    if (!we) begin
      b = (w >> (8 * ln)) & 32'hFF;
      h = (w >> (16 * (ln / 2))) & 32'hFFFF;
      case (f3)
        3'd0: rd = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
        3'd1: rd = (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
        3'd2: rd = w;
        3'd4: rd = b;
        3'd5: rd = h;
        default: rd = 32'd0;
      endcase
    end else begin
      case (f3)
        3'd0: begin
          mask = 32'hFF << (8 * ln);
          mdl[widx] = (w & ~mask) | ((wdata & 32'hFF) << (8 * ln));
        end
        3'd1: begin
          mask = 32'hFFFF << (16 * (ln / 2));
          mdl[widx] = (w & ~mask) | ((wdata & 32'hFFFF) << (16 * (ln / 2)));
        end
        default: mdl[widx] = wdata;
      endcase
    end
  endfunction

  // One full transaction. lat counts clock edges from the accept edge
  // (inclusive) up to the edge after which resp_valid is seen.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clockMem);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    @(posedge clockMem);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    @(negedge clockMem);
    while (!resp_valid && lat < 40) begin
      @(posedge clockMem);
      lat++;
      @(negedge clockMem);
    end
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp_valid_timeout: got 0 expected 1");
    end
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clockMem);
      @(negedge clockMem);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_err", 32'(resp_err), 32'(er));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clockMem);
    #1;
    chk("resp_valid_clear", 32'(resp_valid), 32'd0);
  endtask

  logic [31:0] rd, exp_rd;
  logic        er, exp_err;
  int          lat;

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clockMem);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    @(negedge clockMem);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) begin
      txn(1'b1, 3'd2, BASE + 32'(4 * i), fill_val(i), 0, rd, er, lat);
      model(1'b1, 3'd2, BASE + 32'(4 * i), fill_val(i), exp_rd, exp_err);
    end

    // Directed vectors
    vecs.push_back('{1'b1, 3'b010, 32'h0001_0004, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h0001_0004, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 3'b000, 32'h0001_0006, 32'h0000_0011, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h0001_0004, 32'h0,         32'hDE11_BEEF, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h0001_0007, 32'h0,         32'hFFFF_FFDE, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h0001_0007, 32'h0,         32'h0000_00DE, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h0001_0004, 32'h0,         32'hFFFF_BEEF, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h0001_0004, 32'h0,         32'h0000_BEEF, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b1, 3'b010, 32'h0001_1000, 32'h1111_2222, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h0001_0FFC, 32'h0,         fill_val(DEPTH - 1), 1'b0});
    vecs.push_back('{1'b0, 3'b011, 32'h0001_0000, 32'h0,         32'h0, 1'b1});
    vecs.push_back('{1'b1, 3'b100, 32'h0001_0000, 32'h0,         32'h0, 1'b1});
`ifdef MISALIGN_TRAP_EN
    vecs.push_back('{1'b1, 3'b010, 32'h0001_0002, 32'hCAFE_F00D, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h0001_0000, 32'h0,         fill_val(0), 1'b0});
`else
    vecs.push_back('{1'b1, 3'b010, 32'h0001_0002, 32'hCAFE_F00D, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h0001_0000, 32'h0,         32'hCAFE_F00D, 1'b0});
`endif

    foreach (vecs[i]) begin
      txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0, rd, er, lat);
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, exp_rd, exp_err);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(WAIT_CYCLES + 1));
    end

    // Backpressure: response held for 5 cycles
    txn(1'b0, 3'b010, 32'h0001_0004, 32'h0, 5, rd, er, lat);
    chk("bp_rdata", rd, 32'hDE11_BEEF);
    chk("bp_err", 32'(er), 32'd0);

    // Reset one cycle after accepting a store: no response, no write
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0001_0008;
    req_wdata  = 32'h1234_5678;
    @(posedge clockMem);
    #1;
    req_valid = 1'b0;
    @(posedge clockMem);
    #1;
    reset = 1'b0;
    @(negedge clockMem);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clockMem);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clockMem);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
    end
    txn(1'b0, 3'b010, 32'h0001_0008, 32'h0, 0, rd, er, lat);
    chk("abort_old_value", rd, fill_val(2));

    // Randomized transactions against the reference model
    for (int t = 0; t < 300; t++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      logic [31:0] r_wd;
      int          sel;
      int          r_hold;
      r_we = 1'($urandom);
      sel  = $urandom_range(0, 9);
      if (sel < 3) r_f3 = 3'($urandom);
      else begin
        r_f3 = r_we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
        if (!r_we && r_f3 == 3'd3) r_f3 = 3'd4;
      end
      sel = $urandom_range(0, 9);
      if (sel < 6) r_addr = BASE + 32'($urandom_range(0, 63));
      else if (sel < 9) r_addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      else r_addr = $urandom;
      r_wd   = $urandom;
      r_hold = $urandom_range(0, 2);
      txn(r_we, r_f3, r_addr, r_wd, r_hold, rd, er, lat);
      model(r_we, r_f3, r_addr, r_wd, exp_rd, exp_err);
      chk("rand_rdata", rd, exp_rd);
      chk("rand_err", 32'(er), 32'(exp_err));
      chk("rand_latency", 32'(lat), 32'(WAIT_CYCLES + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
